// File: rtl/puf_response_collector.sv
// puf_response_collector
//   Drives repeated reset/START evaluations of a one_bit_puf cell, majority-votes VOTES
//   samples of its output per response bit, and assembles a RESP_W-bit response plus a
//   per-bit instability mask. The result is offered on a valid/ready handshake.
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   req            start a collection (sampled only while idle)
//   busy           high whenever a collection is in flight or waiting for handoff
//   puf_reset      drives one_bit_puf.reset
//   puf_start      drives one_bit_puf.START
//   puf_out        one_bit_puf.OUT, asynchronous; double-flopped internally
//   resp_data      voted response, first-collected bit in the MSB
//   resp_unstable  bit i set when the votes for resp_data[i] disagreed
//   resp_valid     response available
//   resp_ready     consumer accepts when resp_valid & resp_ready
module puf_response_collector #(
  parameter int unsigned RESP_W  = 8,
  parameter int unsigned VOTES   = 3,
  parameter int unsigned ARM_CYC = 2,
  parameter int unsigned SETTLE  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              busy,
  output logic              puf_reset,
  output logic              puf_start,
  input  logic              puf_out,
  output logic [RESP_W-1:0] resp_data,
  output logic [RESP_W-1:0] resp_unstable,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int unsigned CntMax = (ARM_CYC > SETTLE) ? ARM_CYC : SETTLE;
  localparam int unsigned CycW   = $clog2(CntMax + 1);
  localparam int unsigned VoteW  = $clog2(VOTES + 1);
  localparam int unsigned BitW   = $clog2(RESP_W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFire,
    StSample,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [CycW-1:0]   cyc_q, cyc_d;
  logic [VoteW-1:0]  vote_q, vote_d;
  logic [VoteW-1:0]  ones_q, ones_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [RESP_W-1:0] data_q, data_d;
  logic [RESP_W-1:0] mask_q, mask_d;

  logic [VoteW-1:0]  ones_total;
  logic              bit_dec;
  logic              bit_unstable;

  assign resp_data     = data_q;
  assign resp_unstable = mask_q;

  // Running total including the sample captured this cycle.
  assign ones_total   = ones_q + VoteW'(sync_q[1]);
  assign bit_dec      = (ones_total > VoteW'(VOTES / 2));
  assign bit_unstable = (ones_total != '0) && (ones_total != VoteW'(VOTES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sync_q  <= 2'b00;
      cyc_q   <= '0;
      vote_q  <= '0;
      ones_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], puf_out};
      cyc_q   <= cyc_d;
      vote_q  <= vote_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    vote_d     = vote_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    data_d     = data_q;
    mask_d     = mask_q;
    busy       = 1'b1;
    puf_reset  = 1'b1;
    puf_start  = 1'b0;
    resp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (req) begin
          state_d = StArm;
          cyc_d   = '0;
          vote_d  = '0;
          ones_d  = '0;
          bit_d   = '0;
          mask_d  = '0;
        end
      end

      StArm: begin
        if (cyc_q == CycW'(ARM_CYC - 1)) begin
          cyc_d   = '0;
          state_d = StFire;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StFire: begin
        puf_reset = 1'b0;
        puf_start = 1'b1;
        if (cyc_q == CycW'(SETTLE - 1)) begin
          cyc_d   = '0;
          state_d = StSample;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      StSample: begin
        puf_reset = 1'b0;
        puf_start = 1'b1;
        if (vote_q == VoteW'(VOTES - 1)) begin
          // Last vote for this bit: shift the decision in at the LSB.
          data_d = (data_q << 1) | RESP_W'(bit_dec);
          mask_d = (mask_q << 1) | RESP_W'(bit_unstable);
          vote_d = '0;
          ones_d = '0;
          if (bit_q == BitW'(RESP_W - 1)) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = StArm;
          end
        end else begin
          vote_d  = vote_q + 1'b1;
          ones_d  = ones_total;
          state_d = StArm;
        end
      end

      StDone: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_puf_response_collector.sv
module tb_puf_response_collector;

  localparam int unsigned RespW  = 8;
  localparam int unsigned Votes  = 3;
  localparam int unsigned ArmCyc = 2;
  localparam int unsigned Settle = 4;
  localparam int unsigned NEv    = RespW * Votes;
  localparam int unsigned Lat    = RespW * Votes * (ArmCyc + Settle + 1);

  typedef struct packed {
    logic [RespW-1:0] d;
    logic [RespW-1:0] u;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             busy;
  logic             puf_reset;
  logic             puf_start;
  logic             puf_out;
  logic [RespW-1:0] resp_data;
  logic [RespW-1:0] resp_unstable;
  logic             resp_valid;
  logic             resp_ready;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t exp_q[$];
  bit   ev_q[$];
  int   req_edge_q[$];

  puf_response_collector #(
    .RESP_W (RespW),
    .VOTES  (Votes),
    .ARM_CYC(ArmCyc),
    .SETTLE (Settle)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .busy         (busy),
    .puf_reset    (puf_reset),
    .puf_start    (puf_start),
    .puf_out      (puf_out),
    .resp_data    (resp_data),
    .resp_unstable(resp_unstable),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: majority of each group of Votes evaluations; first group lands in the MSB.
  function automatic exp_t model(input bit ev[NEv]);
    exp_t e;
    e = '0;
    for (int b = 0; b < RespW; b++) begin
      int ones = 0;
      for (int v = 0; v < Votes; v++) ones += int'(ev[b * Votes + v]);
      e.d[RespW - 1 - b] = (2 * ones > Votes);
      e.u[RespW - 1 - b] = (ones != 0) && (ones != Votes);
    end
    return e;
  endfunction

  // Queue the evaluation plan and expected response, then pulse req for one edge.
  task automatic issue(input bit ev[NEv], input bit hold_req);
    foreach (ev[i]) ev_q.push_back(ev[i]);
    exp_q.push_back(model(ev));
    req_edge_q.push_back(cyc + 1);
    req = 1'b1;
    @(negedge clk);
    if (!hold_req) req = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!resp_valid && n < Lat + 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) check("valid_timeout", {31'd0, resp_valid}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_after_handshake", {31'd0, busy}, 32'd0);
  endtask

  // PUF cell model: output cleared while held in reset, takes the next planned value once START rises.
  initial begin
    bit armed = 1'b1;
    puf_out = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || puf_reset) begin
        puf_out = 1'b0;
        armed   = 1'b1;
      end else if (puf_start && armed) begin
        armed = 1'b0;
        if (ev_q.size() > 0) puf_out = ev_q.pop_front();
        else puf_out = 1'b0;
      end
    end
  end

  // Scoreboard monitor: sampled just before each rising edge.
  initial begin
    bit   prev_v = 1'b0;
    exp_t e;
    int   re;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (resp_valid && !prev_v) begin
          if (req_edge_q.size() == 0) begin
            fails++;
            $display("FAIL valid_without_request: resp_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            re = req_edge_q.pop_front();
            check("latency", cyc - re, Lat);
          end
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_response: data %0h with empty scoreboard", resp_data);
          end else begin
            e = exp_q.pop_front();
            check("resp_data", resp_data, e.d);
            check("resp_unstable", resp_unstable, e.u);
          end
        end
        prev_v = resp_valid;
      end
    end
  end

  // Evaluation waveform: ArmCyc busy reset-high cycles, then Settle+1 start-high cycles, no overlap.
  initial begin
    int rrun = 0;
    int srun = 0;
    bit ovl  = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        rrun = 0;
        srun = 0;
        ovl  = 1'b0;
      end else begin
        if (puf_reset && puf_start) ovl = 1'b1;
        if (puf_start) begin
          if (srun == 0) begin
            check("arm_len", rrun, ArmCyc);
            rrun = 0;
          end
          srun++;
        end else if (srun != 0) begin
          check("start_len", srun, Settle + 1);
          check("no_overlap", {31'd0, ovl}, 32'd0);
          srun = 0;
          ovl  = 1'b0;
        end
        if (puf_reset && busy) rrun++;
        else if (!busy) rrun = 0;
      end
    end
  end

  initial begin
    bit   ev[NEv];
    exp_t held;
    bit   stable;
    logic [7:0] pat;

    reset      = 1'b1;
    req        = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_puf_reset", {31'd0, puf_reset}, 32'd1);
    check("rst_puf_start", {31'd0, puf_start}, 32'd0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_unstable", resp_unstable, 0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Constant one.
    foreach (ev[i]) ev[i] = 1'b1;
    issue(ev, 1'b0);
    wait_valid();
    @(negedge clk);
    wait_idle();

    // 8'hA5, unanimous.
    pat = 8'hA5;
    foreach (ev[i]) ev[i] = pat[RespW - 1 - i / Votes];
    issue(ev, 1'b0);
    wait_valid();
    @(negedge clk);
    wait_idle();

    // Split votes on the first two bits.
    foreach (ev[i]) ev[i] = 1'b0;
    ev[0] = 1'b1; ev[1] = 1'b0; ev[2] = 1'b1;
    ev[3] = 1'b0; ev[4] = 1'b1; ev[5] = 1'b0;
    issue(ev, 1'b0);
    wait_valid();
    @(negedge clk);
    wait_idle();

    // Random plans with random consumer back-pressure.
    for (int r = 0; r < 3; r++) begin
      foreach (ev[i]) ev[i] = bit'($urandom_range(0, 1));
      resp_ready = 1'b0;
      issue(ev, 1'b0);
      wait_valid();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      wait_idle();
    end

    // Stall in the response state; a req pulse there must be ignored.
    foreach (ev[i]) ev[i] = bit'($urandom_range(0, 1));
    resp_ready = 1'b0;
    issue(ev, 1'b0);
    wait_valid();
    held   = exp_q[0];
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req = (i == 5);
      @(negedge clk);
      if (resp_data !== held.d || resp_unstable !== held.u || !resp_valid) stable = 1'b0;
    end
    req = 1'b0;
    check("stall_stable", {31'd0, stable}, 32'd1);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_valid", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    check("handoff_valid_drop", {31'd0, resp_valid}, 32'd0);
    check("handoff_busy_drop", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("req_not_queued", {31'd0, busy}, 32'd0);

    // req held through the handshake: IDLE for one cycle, then the next collection starts.
    foreach (ev[i]) ev[i] = bit'($urandom_range(0, 1));
    issue(ev, 1'b1);
    wait_valid();
    foreach (ev[i]) ev[i] = bit'($urandom_range(0, 1));
    foreach (ev[i]) ev_q.push_back(ev[i]);
    exp_q.push_back(model(ev));
    req_edge_q.push_back(cyc + 2);
    @(negedge clk);
    check("held_req_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("held_req_restart", {31'd0, busy}, 32'd1);
    req = 1'b0;
    wait_valid();
    @(negedge clk);
    wait_idle();

    // Abort mid-collection with an asynchronous reset.
    foreach (ev[i]) ev[i] = 1'b1;
    issue(ev, 1'b0);
    repeat (49) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_puf_reset", {31'd0, puf_reset}, 32'd1);
    check("abort_puf_start", {31'd0, puf_start}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, resp_valid}, 32'd0);
    ev_q.delete();
    exp_q.delete();
    req_edge_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    foreach (ev[i]) ev[i] = bit'($urandom_range(0, 1));
    issue(ev, 1'b0);
    wait_valid();
    @(negedge clk);
    wait_idle();

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
